// File: rtl/sfp_ctrl_pkg.sv
// Shared definitions for the SFP accumulate/activation sequencer.
//  state_e    : sequencer FSM states
//  L1_RD_LAT  : L1 SRAM read latency in cycles
//  DRAIN_CYC  : cycles spent in DRAIN (derived from the read latency)
package sfp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    localparam int L1_RD_LAT = 1;

    // The last read data lands L1_RD_LAT cycles after the final read, and the
    // accumulator register needs one more cycle to settle before write-out.
    localparam int DRAIN_CYC = L1_RD_LAT + 1;
    localparam int DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

endpackage

// File: rtl/sfp_ctrl_addr_gen.sv
// Address generator for the SFP sequencer.
// Holds the linear L1 read pointer, the output SRAM pointer and the
// tile (t) / output (o) counters with their last-flags.
//  load       : accepted start, loads bases and zeroes counters
//  l1_base    : first L1 address (sampled on load)
//  out_base   : first output address (sampled on load)
//  tiles/outs : latched T / N
//  tile_step  : one L1 read issued this cycle
//  out_step   : one output word written this cycle
//  l1_ptr     : current L1 read address
//  out_ptr    : current output write address
//  t_last     : current tile is the last of this output
//  o_last     : current output is the last of the job
module sfp_ctrl_addr_gen #(
    parameter int L1_ADDR_W  = 11,
    parameter int OUT_ADDR_W = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [L1_ADDR_W-1:0]  l1_base,
    input  logic [OUT_ADDR_W-1:0] out_base,
    input  logic [CNT_W-1:0]      tiles,
    input  logic [CNT_W-1:0]      outs,
    input  logic                  tile_step,
    input  logic                  out_step,
    output logic [L1_ADDR_W-1:0]  l1_ptr,
    output logic [OUT_ADDR_W-1:0] out_ptr,
    output logic                  t_last,
    output logic                  o_last
);

    logic [L1_ADDR_W-1:0]  l1_ptr_q, l1_ptr_d;
    logic [OUT_ADDR_W-1:0] out_ptr_q, out_ptr_d;
    logic [CNT_W-1:0]      t_q, t_d;
    logic [CNT_W-1:0]      o_q, o_d;

    // Comparing against count-1 keeps the counters within CNT_W bits, so
    // T = 2^CNT_W-1 never needs the unrepresentable value 2^CNT_W.
    assign t_last  = (t_q == tiles - CNT_W'(1));
    assign o_last  = (o_q == outs - CNT_W'(1));
    assign l1_ptr  = l1_ptr_q;
    assign out_ptr = out_ptr_q;

    always_comb begin
        l1_ptr_d  = l1_ptr_q;
        out_ptr_d = out_ptr_q;
        t_d       = t_q;
        o_d       = o_q;
        if (load) begin
            l1_ptr_d  = l1_base;
            out_ptr_d = out_base;
            t_d       = '0;
            o_d       = '0;
        end else begin
            // The L1 pointer is never rewound between outputs: it walks
            // linearly across the whole job and wraps naturally.
            if (tile_step) begin
                l1_ptr_d = l1_ptr_q + L1_ADDR_W'(1);
                t_d      = t_last ? '0 : t_q + CNT_W'(1);
            end
            if (out_step) begin
                out_ptr_d = out_ptr_q + OUT_ADDR_W'(1);
                o_d       = o_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l1_ptr_q  <= '0;
            out_ptr_q <= '0;
            t_q       <= '0;
            o_q       <= '0;
        end else begin
            l1_ptr_q  <= l1_ptr_d;
            out_ptr_q <= out_ptr_d;
            t_q       <= t_d;
            o_q       <= o_d;
        end
    end

endmodule

// File: rtl/sfp_ctrl.sv
// Sequencer for the SFP accumulate/activation stage.
// For each of N outputs: clear the accumulator, stream T psum vectors from
// L1 into the SFP, wait for the pipeline to drain, write the result out.
//  clk, reset        : clock, synchronous active-high reset
//  start / done      : job launch (IDLE only) / one-cycle completion pulse
//  cfg_*             : job configuration, latched on accepted start
//  busy              : job in progress (CLEAR..WRITE)
//  l1_cen, l1_addr   : L1 SRAM read port
//  sfp_valid/clr/relu: SFP accumulate strobe, accumulator clear, ReLU enable
//  out_wen, out_addr : output SRAM write port
// Optional build macro SFP_CTRL_PERF_EN adds perf_cycles / perf_jobs.
module sfp_ctrl
    import sfp_ctrl_pkg::*;
#(
    parameter int L1_ADDR_W  = 11,
    parameter int OUT_ADDR_W = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_tiles,
    input  logic [CNT_W-1:0]      cfg_outs,
    input  logic                  cfg_relu,
    input  logic [L1_ADDR_W-1:0]  cfg_l1_base,
    input  logic [OUT_ADDR_W-1:0] cfg_out_base,
    output logic                  busy,
    output logic                  done,
    output logic                  l1_cen,
    output logic [L1_ADDR_W-1:0]  l1_addr,
    output logic                  sfp_valid,
    output logic                  sfp_clr,
    output logic                  sfp_relu,
    output logic                  out_wen,
`ifdef SFP_CTRL_PERF_EN
    output logic [31:0]           perf_cycles,
    output logic [15:0]           perf_jobs,
`endif
    output logic [OUT_ADDR_W-1:0] out_addr
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     tiles_q, tiles_d;
    logic [CNT_W-1:0]     outs_q, outs_d;
    logic                 relu_q, relu_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    // Delays the read strobe by the L1 read latency so sfp_valid lines up
    // with returning read data.
    logic [L1_RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

    logic                  load, tile_step, out_step, t_last, o_last;
    logic [L1_ADDR_W-1:0]  l1_ptr;
    logic [OUT_ADDR_W-1:0] out_ptr;

    sfp_ctrl_addr_gen #(
        .L1_ADDR_W (L1_ADDR_W),
        .OUT_ADDR_W(OUT_ADDR_W),
        .CNT_W     (CNT_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .l1_base  (cfg_l1_base),
        .out_base (cfg_out_base),
        .tiles    (tiles_q),
        .outs     (outs_q),
        .tile_step(tile_step),
        .out_step (out_step),
        .l1_ptr   (l1_ptr),
        .out_ptr  (out_ptr),
        .t_last   (t_last),
        .o_last   (o_last)
    );

    always_comb begin
        state_d    = state_q;
        tiles_d    = tiles_q;
        outs_d     = outs_q;
        relu_d     = relu_q;
        drain_d    = drain_q;
        load       = 1'b0;
        tile_step  = 1'b0;
        out_step   = 1'b0;
        done       = 1'b0;
        l1_cen     = 1'b0;
        sfp_clr    = 1'b0;
        out_wen    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    tiles_d = cfg_tiles;
                    outs_d  = cfg_outs;
                    relu_d  = cfg_relu;
                    // An empty job goes straight to DONE with no traffic.
                    state_d = (cfg_tiles != '0 && cfg_outs != '0) ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                sfp_clr = 1'b1;
                state_d = ACCUM;
            end
            ACCUM: begin
                l1_cen    = 1'b1;
                tile_step = 1'b1;
                if (t_last) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = WRITE;
            end
            WRITE: begin
                out_wen  = 1'b1;
                out_step = 1'b1;
                state_d  = o_last ? DONE : CLEAR;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == CLEAR) || (state_q == ACCUM) ||
                        (state_q == DRAIN) || (state_q == WRITE);
    assign sfp_relu   = busy & relu_q;
    assign l1_addr    = l1_cen ? l1_ptr : '0;
    assign out_addr   = out_wen ? out_ptr : '0;
    assign vld_pipe_d = L1_RD_LAT'({vld_pipe_q, l1_cen});
    assign sfp_valid  = vld_pipe_q[L1_RD_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tiles_q    <= '0;
            outs_q     <= '0;
            relu_q     <= 1'b0;
            drain_q    <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            tiles_q    <= tiles_d;
            outs_q     <= outs_d;
            relu_q     <= relu_d;
            drain_q    <= drain_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

`ifdef SFP_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [15:0] perf_jobs_q, perf_jobs_d;

    // Counts every active cycle of the job, CLEAR through the DONE cycle.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_jobs_d   = perf_jobs_q;
        if (load)
            perf_cycles_d = '0;
        else if (state_q != IDLE && perf_cycles_q != '1)
            perf_cycles_d = perf_cycles_q + 32'd1;
        if (done) perf_jobs_d = perf_jobs_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_jobs_q   <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_jobs_q   <= perf_jobs_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_jobs   = perf_jobs_q;
`endif

endmodule
